// File: rtl/ddram_arb.sv
// ddram_arb: round-robin scheduler sharing one 64-bit DDR3 Avalon-MM port between two
// requesters. Write bursts hold the grant; read beats return via an in-order tag FIFO.
module ddram_arb #(
  parameter int AW   = 29,
  parameter int DW   = 64,
  parameter int BCW  = 8,
  parameter int TAGS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AW-1:0]     rq0_addr,
  input  logic [BCW-1:0]    rq0_bcnt,
  input  logic              rq0_rd,
  input  logic              rq0_we,
  input  logic [DW-1:0]     rq0_din,
  input  logic [DW/8-1:0]   rq0_be,
  output logic              rq0_busy,
  input  logic [AW-1:0]     rq1_addr,
  input  logic [BCW-1:0]    rq1_bcnt,
  input  logic              rq1_rd,
  input  logic              rq1_we,
  input  logic [DW-1:0]     rq1_din,
  input  logic [DW/8-1:0]   rq1_be,
  output logic              rq1_busy,
  output logic [DW-1:0]     rq_dout,
  output logic              rq0_dout_ready,
  output logic              rq1_dout_ready,
  output logic [AW-1:0]     mem_addr,
  output logic [BCW-1:0]    mem_bcnt,
  output logic              mem_rd,
  output logic              mem_we,
  output logic [DW-1:0]     mem_din,
  output logic [DW/8-1:0]   mem_be,
  input  logic              mem_busy,
  input  logic [DW-1:0]     mem_dout,
  input  logic              mem_dout_ready,
  output logic              err
);
  localparam int TW = $clog2(TAGS);
  localparam logic [TW:0] TAGS_C = (TW+1)'(TAGS);

  typedef enum logic [1:0] {IDLE, CMD, WDATA} state_t;

  state_t          state_q;
  logic            sel_q;
  logic            last_q;
  logic            err_q;
  logic [BCW-1:0]  beats_left_q;
  logic [BCW-1:0]  wbcnt_q;
  logic [AW-1:0]   waddr_q;
  logic [BCW-1:0]  head_rcv_q;
  logic [TW-1:0]   wr_ptr_q;
  logic [TW-1:0]   rd_ptr_q;
  logic [TW:0]     count_q;
  logic [DW-1:0]   dout_q;
  logic            rdy0_q;
  logic            rdy1_q;
  logic            tag_own_q [TAGS];
  logic [BCW-1:0]  tag_len_q [TAGS];

  logic            s_rd, s_we, sel_busy, tagfull;
  logic [AW-1:0]   s_addr;
  logic [BCW-1:0]  s_bcnt, s_len;
  logic [DW-1:0]   s_din;
  logic [DW/8-1:0] s_be;
  logic            rd_acc, wr_acc, beat, pop, head_own, head_done;
  logic            rq0_pend, rq1_pend;

  assign s_rd   = sel_q ? rq1_rd   : rq0_rd;
  assign s_we   = sel_q ? rq1_we   : rq0_we;
  assign s_addr = sel_q ? rq1_addr : rq0_addr;
  assign s_bcnt = sel_q ? rq1_bcnt : rq0_bcnt;
  assign s_din  = sel_q ? rq1_din  : rq0_din;
  assign s_be   = sel_q ? rq1_be   : rq0_be;
  // A burstcount of zero is a single-beat transfer.
  assign s_len  = (s_bcnt == '0) ? BCW'(1) : s_bcnt;

  assign tagfull  = (count_q == TAGS_C);
  assign rq0_pend = rq0_rd | rq0_we;
  assign rq1_pend = rq1_rd | rq1_we;

  always_comb begin
    mem_rd   = 1'b0;
    mem_we   = 1'b0;
    sel_busy = 1'b1;
    mem_addr = s_addr;
    mem_bcnt = s_bcnt;
    mem_din  = s_din;
    mem_be   = s_be;
    case (state_q)
      CMD: begin
        mem_rd   = s_rd & ~tagfull;
        mem_we   = s_we & ~s_rd;
        sel_busy = mem_busy | (s_rd & tagfull);
      end
      WDATA: begin
        mem_we   = s_we;
        mem_addr = waddr_q;
        mem_bcnt = wbcnt_q;
        sel_busy = mem_busy;
      end
      default: ;
    endcase
  end

  assign rq0_busy = sel_q ? 1'b1 : sel_busy;
  assign rq1_busy = sel_q ? sel_busy : 1'b1;

  assign rd_acc    = mem_rd & ~mem_busy;
  assign wr_acc    = mem_we & ~mem_busy;
  assign beat      = mem_dout_ready & (count_q != '0);
  assign head_own  = tag_own_q[rd_ptr_q];
  assign head_done = (head_rcv_q == tag_len_q[rd_ptr_q] - BCW'(1));
  assign pop       = beat & head_done;

  // Tag storage holds data only; validity comes from count_q.
  always_ff @(posedge clk) begin
    if (rd_acc) begin
      tag_own_q[wr_ptr_q] <= sel_q;
      tag_len_q[wr_ptr_q] <= s_len;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      last_q       <= 1'b1;
      err_q        <= 1'b0;
      beats_left_q <= '0;
      wbcnt_q      <= '0;
      waddr_q      <= '0;
      head_rcv_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      rdy0_q       <= 1'b0;
      rdy1_q       <= 1'b0;
    end else begin
      dout_q <= mem_dout;
      rdy0_q <= beat & ~head_own;
      rdy1_q <= beat & head_own;
      if (mem_dout_ready && count_q == '0)
        err_q <= 1'b1;

      if (beat) begin
        if (pop) begin
          head_rcv_q <= '0;
          rd_ptr_q   <= rd_ptr_q + TW'(1);
        end else begin
          head_rcv_q <= head_rcv_q + BCW'(1);
        end
      end
      if (rd_acc)
        wr_ptr_q <= wr_ptr_q + TW'(1);
      if (rd_acc && !pop)
        count_q <= count_q + (TW+1)'(1);
      else if (pop && !rd_acc)
        count_q <= count_q - (TW+1)'(1);

      case (state_q)
        IDLE: begin
          if (rq0_pend && rq1_pend) begin
            sel_q   <= ~last_q;
            state_q <= CMD;
          end else if (rq0_pend) begin
            sel_q   <= 1'b0;
            state_q <= CMD;
          end else if (rq1_pend) begin
            sel_q   <= 1'b1;
            state_q <= CMD;
          end
        end
        CMD: begin
          if (rd_acc) begin
            last_q  <= sel_q;
            state_q <= IDLE;
          end else if (wr_acc) begin
            if (s_len == BCW'(1)) begin
              last_q  <= sel_q;
              state_q <= IDLE;
            end else begin
              beats_left_q <= s_len - BCW'(1);
              waddr_q      <= s_addr;
              wbcnt_q      <= s_bcnt;
              state_q      <= WDATA;
            end
          end else if (!(s_rd || s_we)) begin
            state_q <= IDLE;
          end
        end
        WDATA: begin
          if (wr_acc) begin
            beats_left_q <= beats_left_q - BCW'(1);
            if (beats_left_q == BCW'(1)) begin
              last_q  <= sel_q;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rq_dout        = dout_q;
  assign rq0_dout_ready = rdy0_q;
  assign rq1_dout_ready = rdy1_q;
  assign err            = err_q;
endmodule

// File: tb/tb_ddram_arb.sv
// tb_ddram_arb: directed scenarios plus randomized traffic, every cycle checked against a
// transaction-level model (grant owner, outstanding-burst queue) of the arbiter.
module tb_ddram_arb;
  localparam int AW = 29, DW = 64, BCW = 8, TAGS = 4, BEW = DW / 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]  r_addr [2];
  logic [BCW-1:0] r_bcnt [2];
  logic           r_rd [2];
  logic           r_we [2];
  logic [DW-1:0]  r_din [2];
  logic [BEW-1:0] r_be [2];
  logic           mem_busy, mem_dout_ready;
  logic [DW-1:0]  mem_dout;

  logic rq0_busy, rq1_busy, rq0_dout_ready, rq1_dout_ready, mem_rd, mem_we, err;
  logic [DW-1:0]  rq_dout, mem_din;
  logic [AW-1:0]  mem_addr;
  logic [BCW-1:0] mem_bcnt;
  logic [BEW-1:0] mem_be;

  ddram_arb #(.AW(AW), .DW(DW), .BCW(BCW), .TAGS(TAGS)) dut (
    .clk(clk), .reset_n(reset_n),
    .rq0_addr(r_addr[0]), .rq0_bcnt(r_bcnt[0]), .rq0_rd(r_rd[0]), .rq0_we(r_we[0]),
    .rq0_din(r_din[0]), .rq0_be(r_be[0]), .rq0_busy(rq0_busy),
    .rq1_addr(r_addr[1]), .rq1_bcnt(r_bcnt[1]), .rq1_rd(r_rd[1]), .rq1_we(r_we[1]),
    .rq1_din(r_din[1]), .rq1_be(r_be[1]), .rq1_busy(rq1_busy),
    .rq_dout(rq_dout), .rq0_dout_ready(rq0_dout_ready), .rq1_dout_ready(rq1_dout_ready),
    .mem_addr(mem_addr), .mem_bcnt(mem_bcnt), .mem_rd(mem_rd), .mem_we(mem_we),
    .mem_din(mem_din), .mem_be(mem_be), .mem_busy(mem_busy), .mem_dout(mem_dout),
    .mem_dout_ready(mem_dout_ready), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: granted port (-1 = arbitrating), write beats still owed, outstanding read bursts.
  int             m_gnt, m_wleft, m_last;
  logic [AW-1:0]  m_waddr;
  logic [BCW-1:0] m_wbcnt;
  int             q_own[$];
  int             q_left[$];
  bit             e_rdy [2];
  logic [DW-1:0]  e_dout;
  bit             e_err;

  bit             macc [2];
  bit             dacc [2];
  bit             s_rd, s_we, s_err;
  bit             s_b [2];
  bit             s_r [2];
  logic [AW-1:0]  s_addr;
  logic [BCW-1:0] s_bcnt;
  logic [DW-1:0]  s_dout;

  bit rand_en = 1'b0;
  bit op_act [2];
  bit op_wr [2];
  int op_beats [2];
  int op_eff [2];

  function automatic int eff(logic [BCW-1:0] b);
    return (b == '0) ? 1 : int'(b);
  endfunction

  function automatic int outstanding();
    int t = 0;
    foreach (q_left[i]) t += q_left[i];
    return t;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_gnt = -1; m_wleft = 0; m_last = 1;
    q_own.delete(); q_left.delete();
    e_rdy[0] = 0; e_rdy[1] = 0; e_err = 0;
  endtask

  task automatic eval();
    bit full, er, ew;
    bit eb [2];
    bit nr [2];
    int s;
    s_rd = mem_rd; s_we = mem_we; s_err = err; s_b[0] = rq0_busy; s_b[1] = rq1_busy;
    s_r[0] = rq0_dout_ready; s_r[1] = rq1_dout_ready;
    s_addr = mem_addr; s_bcnt = mem_bcnt; s_dout = rq_dout;
    dacc[0] = (r_rd[0] | r_we[0]) & ~rq0_busy;
    dacc[1] = (r_rd[1] | r_we[1]) & ~rq1_busy;
    if (!reset_n) model_reset();
    full = (q_own.size() == TAGS);
    er = 0; ew = 0; eb[0] = 1; eb[1] = 1;
    s = (m_gnt < 0) ? 0 : m_gnt;
    if (m_gnt >= 0) begin
      if (m_wleft == 0) begin
        er = r_rd[s] && !full;
        ew = r_we[s] && !r_rd[s];
        eb[s] = mem_busy || (r_rd[s] && full);
      end else begin
        ew = r_we[s];
        eb[s] = mem_busy;
      end
    end
    chk("busy0", rq0_busy, eb[0]);
    chk("busy1", rq1_busy, eb[1]);
    chk("mem_rd", mem_rd, er);
    chk("mem_we", mem_we, ew);
    chk("dout_ready0", rq0_dout_ready, e_rdy[0]);
    chk("dout_ready1", rq1_dout_ready, e_rdy[1]);
    chk("err", err, e_err);
    if (e_rdy[0] || e_rdy[1]) chk("rq_dout", rq_dout, e_dout);
    if (er || ew) begin
      chk("mem_addr", mem_addr, (m_wleft > 0) ? m_waddr : r_addr[s]);
      chk("mem_bcnt", mem_bcnt, (m_wleft > 0) ? m_wbcnt : r_bcnt[s]);
      chk("mem_din", mem_din, r_din[s]);
      chk("mem_be", mem_be, r_be[s]);
    end
    macc[0] = (r_rd[0] | r_we[0]) && !eb[0];
    macc[1] = (r_rd[1] | r_we[1]) && !eb[1];
    if (!reset_n) return;

    // Return beats belong to the oldest outstanding burst.
    nr[0] = 0; nr[1] = 0;
    if (mem_dout_ready) begin
      if (q_own.size() == 0) e_err = 1;
      else begin
        nr[q_own[0]] = 1;
        q_left[0] = q_left[0] - 1;
        if (q_left[0] == 0) begin
          void'(q_own.pop_front());
          void'(q_left.pop_front());
        end
      end
    end
    e_rdy[0] = nr[0]; e_rdy[1] = nr[1]; e_dout = mem_dout;

    if (m_gnt < 0) begin
      if ((r_rd[0] | r_we[0]) && (r_rd[1] | r_we[1])) m_gnt = 1 - m_last;
      else if (r_rd[0] | r_we[0]) m_gnt = 0;
      else if (r_rd[1] | r_we[1]) m_gnt = 1;
      m_wleft = 0;
    end else if (m_wleft == 0) begin
      if (er && !mem_busy) begin
        q_own.push_back(s); q_left.push_back(eff(r_bcnt[s]));
        m_last = s; m_gnt = -1;
      end else if (ew && !mem_busy) begin
        if (eff(r_bcnt[s]) == 1) begin
          m_last = s; m_gnt = -1;
        end else begin
          m_wleft = eff(r_bcnt[s]) - 1; m_waddr = r_addr[s]; m_wbcnt = r_bcnt[s];
        end
      end else if (!(r_rd[s] || r_we[s])) m_gnt = -1;
    end else if (ew && !mem_busy) begin
      m_wleft = m_wleft - 1;
      if (m_wleft == 0) begin
        m_last = s; m_gnt = -1;
      end
    end
  endtask

  task automatic drive_rand();
    for (int n = 0; n < 2; n++) begin
      if (macc[n]) begin
        if (op_wr[n]) begin
          op_beats[n]--;
          r_din[n] = {$urandom, $urandom};
          r_be[n] = BEW'($urandom);
          if (op_beats[n] == 0) op_act[n] = 0;
        end else op_act[n] = 0;
      end
      if (!op_act[n]) begin
        r_rd[n] = 0; r_we[n] = 0;
        if ($urandom_range(0, 2) == 0) begin
          op_act[n] = 1;
          op_wr[n] = 1'($urandom_range(0, 1));
          r_bcnt[n] = BCW'($urandom_range(0, 4));
          op_eff[n] = eff(r_bcnt[n]);
          op_beats[n] = op_eff[n];
          r_addr[n] = AW'($urandom);
          r_din[n] = {$urandom, $urandom};
          r_be[n] = BEW'($urandom);
          r_rd[n] = !op_wr[n];
          r_we[n] = op_wr[n];
        end
      end else if (op_wr[n] && op_beats[n] < op_eff[n]) begin
        r_we[n] = ($urandom_range(0, 3) != 0);
      end
    end
    mem_busy = ($urandom_range(0, 3) == 0);
    mem_dout_ready = (outstanding() > 0) && ($urandom_range(0, 1) == 1);
    mem_dout = {$urandom, $urandom};
  endtask

  task automatic step();
    @(negedge clk);
    eval();
    @(posedge clk);
    #1;
    if (rand_en) drive_rand();
  endtask

  task automatic idle_inputs();
    for (int n = 0; n < 2; n++) begin
      r_rd[n] = 0; r_we[n] = 0; r_bcnt[n] = 1; r_addr[n] = '0;
      r_din[n] = '0; r_be[n] = '1;
    end
    mem_busy = 0; mem_dout_ready = 0; mem_dout = '0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    idle_inputs();
    step(); step();
    reset_n = 1;
  endtask

  task automatic issue(int n, logic [AW-1:0] a, logic [BCW-1:0] b);
    bit ok = 0;
    r_addr[n] = a; r_bcnt[n] = b; r_rd[n] = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (dacc[n]) begin ok = 1; break; end
    end
    chk("issue_accepted", ok, 1);
    r_rd[n] = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (outstanding() == 0) break;
      mem_dout_ready = 1; mem_dout = 64'hABCD_0000 + 64'(i);
      step();
    end
    mem_dout_ready = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, lo0, lo1, beats, first, lastb, rdstep, viol, rdseen, wseen, nacc;
    bit ok;
    int gseq[$];
    int p_own[$];
    int p_step[$];
    logic [63:0] p_dat[$];
    model_reset();
    idle_inputs();

    // Reset: requests are ignored while held; first grant goes to port 0.
    reset_n = 0;
    r_rd[0] = 1; r_addr[0] = 29'h0ABCDE; r_bcnt[0] = 1;
    step(); step();
    chk("rst_busy0", s_b[0], 1);
    chk("rst_busy1", s_b[1], 1);
    chk("rst_mem_rd", s_rd, 0);
    reset_n = 1;
    got = -1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (s_rd) begin got = i; break; end
    end
    chk("rel_rd_latency", got, 1);
    chk("rel_rd_addr", s_addr, 29'h0ABCDE);
    r_rd[0] = 0;
    mem_dout_ready = 1; mem_dout = 64'h1111;
    step();
    mem_dout_ready = 0;
    step();
    chk("rel_ready0", s_r[0], 1);
    chk("rel_dout", s_dout, 64'h1111);

    // Contention: alternating single-beat reads.
    do_reset();
    r_rd[0] = 1; r_rd[1] = 1; r_addr[0] = 29'h100; r_addr[1] = 29'h200;
    lo0 = 0; lo1 = 0;
    for (int i = 0; i < 16; i++) begin
      mem_dout_ready = (outstanding() > 0); mem_dout = 64'(i);
      step();
      if (!s_b[0]) lo0++;
      if (!s_b[1]) lo1++;
      if (s_rd && gseq.size() < 4) gseq.push_back(s_b[0] ? 1 : 0);
    end
    r_rd[0] = 0; r_rd[1] = 0; mem_dout_ready = 0;
    for (int k = 0; k < 4; k++) chk("cont_grant", (gseq.size() > k) ? gseq[k] : 9, k % 2);
    chk("cont_busy_low0", lo0, 4);
    chk("cont_busy_low1", lo1, 4);
    drain();

    // Routing of return beats to the issuing port.
    do_reset();
    issue(0, 29'h300, 3);
    issue(1, 29'h400, 2);
    for (int i = 0; i < 7; i++) begin
      mem_dout_ready = (i < 5); mem_dout = 64'hD0 + 64'(i);
      step();
      if (s_r[0] || s_r[1]) begin
        p_own.push_back(s_r[1] ? 1 : 0); p_step.push_back(i); p_dat.push_back(s_dout);
      end
    end
    mem_dout_ready = 0;
    chk("route_count", p_own.size(), 5);
    for (int k = 0; k < 5 && k < p_own.size(); k++) begin
      chk("route_owner", p_own[k], (k < 3) ? 0 : 1);
      chk("route_data", p_dat[k], 64'hD0 + 64'(k));
      chk("route_latency", p_step[k], k + 1);
    end

    // Write-burst lock: port 1 wins (last=0) and keeps the grant for all 4 beats.
    do_reset();
    issue(0, 29'h500, 1);
    drain();
    r_rd[0] = 1; r_addr[0] = 29'h600; r_bcnt[0] = 1;
    r_we[1] = 1; r_addr[1] = 29'h700; r_bcnt[1] = 4; r_din[1] = 64'h1000;
    beats = 0; first = -1; lastb = -1; rdstep = -1; viol = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (beats < 4 && !s_b[0]) viol++;
      if (dacc[1] && r_we[1]) begin
        chk("lock_bcnt", s_bcnt, 4);
        if (first < 0) first = i;
        lastb = i; beats++;
        r_din[1] = r_din[1] + 1;
        if (beats == 4) r_we[1] = 0;
      end
      if (dacc[0]) begin rdstep = i; break; end
    end
    r_rd[0] = 0;
    chk("lock_beats", beats, 4);
    chk("lock_back_to_back", lastb - first, 3);
    chk("lock_rq0_held", viol, 0);
    chk("lock_read_after", rdstep > lastb, 1);
    drain();

    // Tag-full stall: 4 reads outstanding block the 5th; a write still gets through.
    do_reset();
    r_rd[0] = 1; r_addr[0] = 29'h800; r_bcnt[0] = 1;
    nacc = 0;
    for (int i = 0; i < 20 && nacc < 4; i++) begin
      step();
      if (dacc[0]) nacc++;
    end
    chk("full_issued4", nacc, 4);
    r_we[1] = 1; r_addr[1] = 29'h900; r_bcnt[1] = 1;
    rdseen = 0; wseen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (s_rd) rdseen++;
      if (dacc[1] && r_we[1]) begin wseen++; r_we[1] = 0; end
    end
    chk("full_no_rd", rdseen, 0);
    chk("full_write_went", wseen, 1);
    chk("full_busy0", s_b[0], 1);
    mem_dout_ready = 1; mem_dout = 64'h55;
    step();
    mem_dout_ready = 0;
    ok = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (dacc[0]) begin ok = 1; break; end
    end
    chk("full_5th_issued", ok, 1);
    r_rd[0] = 0;
    drain();

    // Return beat with nothing outstanding.
    do_reset();
    mem_dout_ready = 1; mem_dout = 64'h77;
    step();
    mem_dout_ready = 0;
    step();
    chk("err_set", s_err, 1);
    chk("err_no_ready0", s_r[0], 0);
    chk("err_no_ready1", s_r[1], 0);

    // Reset in the middle of a write burst with two beats left.
    r_we[1] = 1; r_addr[1] = 29'hA00; r_bcnt[1] = 4;
    beats = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (dacc[1]) beats++;
      if (beats == 2) break;
    end
    chk("mid_beats", beats, 2);
    reset_n = 0;
    step();
    chk("mid_mem_we", s_we, 0);
    chk("mid_err", s_err, 0);
    chk("mid_busy1", s_b[1], 1);
    r_we[1] = 0;
    step();
    reset_n = 1;

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 2; n++) begin op_act[n] = 0; op_wr[n] = 0; op_beats[n] = 0; op_eff[n] = 1; end
    rand_en = 1;
    repeat (3000) step();
    rand_en = 0;
    r_rd[0] = 0; r_rd[1] = 0; r_we[0] = 0; r_we[1] = 0; mem_busy = 0;
    drain();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
